// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage register chain with valid/ready back-pressure, bubble collapse,
// synchronous flush and occupancy. Optional stall/bubble counters: PIPE_STAGE_STATS_EN.
module pipe_stage_chain #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
`ifdef PIPE_STAGE_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    output logic [CNT_W-1:0]  occupancy
);

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  v_nxt;
    logic [DEPTH-1:0]  rdy;
    logic [DATA_W-1:0] d [DEPTH];
    logic [CNT_W-1:0]  cnt_nxt;
    logic              full_run;

    // rdy[i] = !v[i] | rdy[i+1] unrolled as "out_ready, or a hole at/after stage i",
    // which avoids a self-referencing vector in the combinational loop.
    always_comb begin
        rdy      = '0;
        full_run = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            full_run = full_run & v[i];
            rdy[i]   = out_ready | ~full_run;
        end
    end

    always_comb begin
        v_nxt = v;
        if (rdy[0]) v_nxt[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) v_nxt[i] = v[i-1];
        end
        if (flush) v_nxt = '0;
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(v_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_nxt;
            occupancy <= cnt_nxt;
        end
    end

    // Data only moves alongside a valid bit; empty stages keep their stale payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
            if (rdy[0] && in_valid) d[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i] && v[i-1]) d[i] <= d[i-1];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef PIPE_STAGE_STATS_EN
    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (out_ready && !out_valid && bubble_cnt != 32'hFFFF_FFFF)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: slot-list model checked every cycle plus directed literal checks.
module tb_pipe_stage_chain;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pipe_stage_chain #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the chain is a list of slots. When the output stalls, the contiguous
    // full run at the tail is frozen; every slot ahead of it shifts forward by one.
    typedef struct {
        bit          vld;
        logic [63:0] dat;
    } slot_t;
    slot_t m [DEPTH];

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m[i].vld ? 1 : 0;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        int tail;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) m[i] = '{1'b0, 64'd0};
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) m[i] = '{1'b0, 64'd0};
        end else begin
            tail = DEPTH;
            if (!out_ready) while (tail > 0 && m[tail-1].vld) tail--;
            for (int i = tail - 1; i > 0; i--) m[i] = m[i-1];
            if (tail > 0) m[0] = '{in_valid, in_data};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("cyc_in_ready", {63'd0, in_ready}, {63'd0, out_ready || (m_count() < DEPTH)});
            chk("cyc_out_valid", {63'd0, out_valid}, {63'd0, m[DEPTH-1].vld});
            if (m[DEPTH-1].vld) chk("cyc_out_data", out_data, m[DEPTH-1].dat);
            chk("cyc_occupancy", 64'(occupancy), 64'(m_count()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Stream: 4-cycle latency, then one per cycle.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'd1;
        for (int j = 1; j <= 8; j++) begin
            cyc();
            in_data = 64'(j + 1);
            if (j <= 3) chk("stream_latency", {63'd0, out_valid}, 64'd0);
            else begin
                chk("stream_data", out_data, 64'(j - 3));
                chk("stream_occ", 64'(occupancy), 64'd4);
            end
        end
        in_valid = 1'b0;
        repeat (5) cyc();

        // Back-pressure fill.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_data = 64'hA0 + 64'(k);
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, (k < 4) ? 64'd1 : 64'd0);
            if (k < 4) cyc();
        end
        chk("bp_occ", 64'(occupancy), 64'd4);
        out_ready = 1'b1;
        #1;
        chk("bp_passthru_ready", {63'd0, in_ready}, 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain", out_data, 64'hA0 + 64'(k));
            cyc();
            in_valid = 1'b0;
        end
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Bubble collapse.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11;
        cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        in_valid = 1'b1; in_data = 64'h22;
        cyc();
        in_valid = 1'b0;
        repeat (6) cyc();
        chk("bub_occ", 64'(occupancy), 64'd2);
        chk("bub_head", out_data, 64'h11);
        out_ready = 1'b1;
        cyc();
        chk("bub_second", out_data, 64'h22);
        chk("bub_second_v", {63'd0, out_valid}, 64'd1);
        cyc();
        chk("bub_done", {63'd0, out_valid}, 64'd0);

        // Flush with a payload offered in the same cycle.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 64'h31 + 64'(k);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("fl_pre_occ", 64'(occupancy), 64'd3);
        flush = 1'b1; in_valid = 1'b1; in_data = 64'hFF;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_out_data", out_data, 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("fl_no_ff", {63'd0, out_valid}, 64'd0);
        end

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 64'h41 + 64'(k);
            cyc();
        end
        in_valid = 1'b0;
        repeat (2) cyc();
        chk("ar_pre_occ", 64'(occupancy), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_out_data", out_data, 64'd0);
        chk("ar_occ", 64'(occupancy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_in_ready", {63'd0, in_ready}, 64'd1);

`ifdef PIPE_STAGE_STATS_EN
        rst = 1'b0;
        #3;
        rst = 1'b1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h55;
        cyc();
        in_valid = 1'b0;
        begin
            int budget = 20;
            while (!out_valid && budget > 0) begin
                cyc();
                budget--;
            end
            chk("st_wait", {63'd0, out_valid}, 64'd1);
        end
        repeat (7) cyc();
        chk("st_stall", 64'(stall_cnt), 64'd7);
        out_ready = 1'b1;
        cyc();
        repeat (3) cyc();
        chk("st_bubble", 64'(bubble_cnt), 64'd3);
        chk("st_stall_kept", 64'(stall_cnt), 64'd7);
`endif

        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised, elastic successor to the fixed single-purpose stage registers between IF/ID/EXE/MEM/WB.
- Carries a DATA_W-bit payload (default {pc, instruction}) through DEPTH register stages.
- Per-stage valid bits, valid/ready back-pressure with bubble collapsing, synchronous flush, and an occupancy count.
- Sits between two pipeline stages, or between a stage and a downstream unit that can stall.

Parameters:
- DATA_W, 64, payload width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- CNT_W, $clog2(DEPTH+1), width of the occupancy output (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all stages (branch taken / exception).
- in_valid  input  1  upstream payload valid.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  chain accepts in_data this cycle.
- out_valid  output  1  last stage holds valid payload.
- out_data  output  DATA_W  last stage payload.
- out_ready  input  1  downstream consumes out_data this cycle.
- occupancy  output  CNT_W  number of stages currently valid (0..DEPTH).

Behaviour:
- Reset (rst=0, asynchronous): all valid bits 0, all stage data 0, occupancy 0, out_valid 0, out_data 0. in_ready goes to 1 as soon as rst=1.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !v[i] | rdy[i+1], for i = DEPTH-1..0.
  - in_ready = rdy[0].
  - No combinational path from in_valid/in_data to in_ready.
- Stage update on clk rise, for i >= 1, when rdy[i]=1:
  - v[i] <= v[i-1];
  - d[i] <= d[i-1] when v[i-1]=1, else d[i] holds.
- Stage 0 update: when rdy[0]=1, v[0] <= in_valid and d[0] <= in_data (data captured only if in_valid=1).
- A stage with rdy[i]=0 holds both v[i] and d[i].
- Bubble collapse: an empty stage accepts from upstream even while downstream is stalled, so gaps close under back-pressure.
- Latency: with out_ready held 1 and an empty chain, a payload presented at cycle N appears on out_valid/out_data at cycle N+DEPTH.
- Throughput: 1 payload/cycle when out_ready=1.
- Full: all v=1 and out_ready=0 -> in_ready=0 and all stages hold. If out_ready=1 while full, in_ready=1 in the same cycle (pass-through).
- Empty: out_valid=0. Data on out_data is don't-care but must equal the last stage register.
- Flush (synchronous, priority over everything):
  - all v <= 0 and all d <= 0; occupancy becomes 0 next cycle.
  - A payload offered with in_valid=1 in the flush cycle is dropped even if in_ready=1.
  - An out_valid/out_ready transfer in the flush cycle still counts as consumed by downstream.
- occupancy: registered popcount of v, updated on the same edge as v; equals 0 after reset or flush.
- Reset mid-operation: all in-flight payloads are lost, outputs are zero immediately, with no waiting for a clock edge.
- DEPTH=1: degenerates to a single elastic register, where in_ready = !v[0] | out_ready.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt [31:0]: increments each cycle out_valid=1 and out_ready=0.
  - bubble_cnt [31:0]: increments each cycle out_ready=1 and out_valid=0.
- Both counters saturate at 32'hFFFFFFFF, clear on rst, and are not cleared by flush.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then stream: DEPTH=4, out_ready=1, in_data=1,2,3,... on consecutive cycles -> out_data 1 appears exactly 4 cycles after it was offered, then one value per cycle in order; occupancy holds at 4.
- Back-pressure fill: out_ready=0, offer 5 payloads (0xA0..0xA4) -> 4 accepted, in_ready=0 on the 5th, occupancy=4. Raise out_ready -> 0xA0..0xA4 emerge in order with no loss or duplication.
- Bubble collapse: send 0x11, idle 2 cycles, send 0x22 with out_ready=0 -> 0x11 and 0x22 end in adjacent stages (occupancy=2). On release, they exit on consecutive cycles.
- Flush: chain holding 3 valid payloads, assert flush together with in_valid=1/in_data=0xFF -> next cycle occupancy=0 and out_valid=0; 0xFF never appears at the output.
- Async reset mid-stream: drop rst between clock edges with occupancy=3 -> out_valid=0, out_data=0, occupancy=0 immediately.
- Stats (PIPE_STAGE_STATS_EN): hold out_ready=0 for 7 cycles with out_valid=1 -> stall_cnt=7. Then hold out_ready=1 for 3 cycles with an empty chain -> bubble_cnt=3.
